pipe_skid_buffer: RTL and testbench
===================================

Name: pipe_skid_buffer

Overview:
Parametrised inter-stage pipeline buffer for the five-stage processor. It replaces the fixed 16-bit, always-transferring stage register with a two-entry, valid/ready-handshaked register. The block supports stall (back-pressure), synchronous flush (bubble insertion on branch/hazard), and a configurable bubble/NOP encoding. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries the packed stage word.

Parameters:
WIDTH, 16, bit width of the packed stage word.
BUBBLE, {WIDTH{1'b0}}, value driven on out_data whenever out_valid=0 (NOP encoding).

Ports:
clk  input  1  single clock; all state changes on posedge.
rst  input  1  asynchronous, active-low reset.
in_valid  input  1  upstream stage presents a word.
in_ready  output  1  buffer can accept; registered, equals NOT skid_valid.
in_data  input  WIDTH  upstream stage word.
out_valid  output  1  main entry holds a valid word.
out_ready  input  1  downstream stage consumes (0 = stall).
out_data  output  WIDTH  main entry data, or BUBBLE when out_valid=0.
flush  input  1  synchronous kill of all held and in-flight words.
count  output  2  occupancy, 0..2.

Behaviour:
- Storage: main entry (data+valid) drives the outputs; skid entry (data+valid) absorbs one word while downstream stalls.
- Transfers:
  - accept = in_valid & in_ready.
  - consume = out_valid & out_ready.
  - Both are evaluated at posedge clk.
- States by count:
  - EMPTY (0): accept -> main<=in_data, ONE.
  - ONE (1): accept&consume -> main<=in_data, stay ONE. accept only -> skid<=in_data, FULL. consume only -> EMPTY. Neither -> hold.
  - FULL (2): in_ready=0, so accept is impossible. consume -> main<=skid, skid invalid, ONE. Otherwise hold.
- Latency: a word accepted at edge N is on out_data with out_valid=1 immediately after edge N. Full throughput is 1 word/cycle when out_ready is held at 1.
- in_ready depends only on registered state; there is no combinational path from out_ready to in_ready.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid do not change (except on flush or reset).
- Ordering: words leave in strict acceptance order; there is no loss or duplication.
- Flush:
  - At the edge with flush=1, main and skid both become invalid and count becomes 0.
  - Any word offered in that cycle is discarded, even if in_ready=1.
  - Any consume in that cycle still counts as taken by downstream.
  - Flush has priority over every other event.
  - After the flush edge: out_valid=0, out_data=BUBBLE, in_ready=1.
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=BUBBLE, in_ready=1, count=0.
  - Both valid bits clear immediately without a clock; data registers clear to BUBBLE.
  - No transfer occurs while rst=0.
  - Reset mid-operation drops all held words; the first accept is possible at the first posedge after rst rises.
- Width rules: all data paths are exactly WIDTH bits; count saturates structurally at 2 (the FULL state blocks accept). X on in_data with in_valid=0 must never reach out_data.

Test Plan:
- Reset check: hold rst=0 with no clocks -> out_valid=0, out_data=BUBBLE (0x0000), in_ready=1, count=0; pulse rst low mid-stream -> same values immediately, without a clock edge.
- Streaming: out_ready=1, in_valid=1, in_data=0x1111,0x2222,0x3333 on consecutive edges -> out_data shows the same sequence one per cycle with out_valid=1; count stays 1; in_ready stays 1.
- Stall/skid: load 0xAAAA, then set out_ready=0 and offer 0xBBBB -> count=2, in_ready=0, out_data holds 0xAAAA; offer 0xCCCC while stalled -> not accepted. Release out_ready -> out_data 0xAAAA, then 0xBBBB; 0xCCCC is accepted only after in_ready returns to 1.
- Flush at FULL: count=2 holding 0x1234/0x5678, assert flush with in_valid=1, in_data=0x9999 -> next cycle out_valid=0, out_data=BUBBLE, count=0; 0x9999 never appears on out_data.
- Simultaneous accept+consume at ONE with out_ready=1: main 0x0001, offer 0x0002 -> count stays 1, out_data=0x0002.
- Parameter sweep: WIDTH=32, BUBBLE=32'h00000013 -> idle out_data=0x00000013; the streaming test passes with 32-bit values; a random valid/ready scoreboard over 10k cycles shows no loss, duplication or reordering.

Source files
------------

// File: rtl/pipe_skid_buffer_if.sv
// rtl/pipe_skid_buffer_if.sv - handshake bundle for the inter-stage skid buffer
// master drives words in and consumes words out; slave is the buffer itself.
interface pipe_skid_buffer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       count;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_skid_buffer.sv
// rtl/pipe_skid_buffer.sv - two-entry valid/ready pipeline stage register with flush
// Main entry drives the outputs; the skid entry catches one word while downstream stalls.
module pipe_skid_buffer #(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  pipe_skid_buffer_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             consume;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  // The state encoding is the occupancy, so in_ready and count come straight from flops.
  assign accept  = bus.in_valid & (state != FULL);
  assign consume = bus.out_ready & (state != EMPTY);

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (bus.flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_nxt    = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (consume) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            load_main_skid = 1'b1;
            state_nxt      = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      main_data <= BUBBLE;
      skid_data <= BUBBLE;
    end else begin
      state <= state_nxt;
      if (load_main_in) begin
        main_data <= bus.in_data;
      end else if (load_main_skid) begin
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_data <= bus.in_data;
      end
    end
  end

  assign bus.out_valid = (state != EMPTY);
  assign bus.in_ready  = (state != FULL);
  assign bus.count     = state;
  assign bus.out_data  = (state != EMPTY) ? main_data : BUBBLE;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// tb/tb_pipe_skid_buffer.sv - scoreboard bench for pipe_skid_buffer at 16 and 32 bits
// Both instances see the same handshakes; the 32-bit word is {~d, d} of the 16-bit word d.
module tb_pipe_skid_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] q[$];
  int          occ = 0;

  pipe_skid_buffer_if #(.WIDTH(16)) b16 ();
  pipe_skid_buffer_if #(.WIDTH(32)) b32 ();

  assign b16.in_valid  = in_valid;
  assign b16.in_data   = in_data;
  assign b16.out_ready = out_ready;
  assign b16.flush     = flush;
  assign b32.in_valid  = in_valid;
  assign b32.in_data   = {~in_data, in_data};
  assign b32.out_ready = out_ready;
  assign b32.flush     = flush;

  pipe_skid_buffer #(.WIDTH(16), .BUBBLE(16'h0000)) u16 (.clk(clk), .rst(rst), .bus(b16));
  pipe_skid_buffer #(.WIDTH(32), .BUBBLE(32'h00000013)) u32 (.clk(clk), .rst(rst), .bus(b32));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every cycle against the scoreboard, pops on each consume.
  always @(negedge clk) begin
    chk("count16", 32'(b16.count), 32'(occ));
    chk("count32", 32'(b32.count), 32'(occ));
    chk("in_ready16", 32'(b16.in_ready), 32'(occ != 2));
    chk("in_ready32", 32'(b32.in_ready), 32'(occ != 2));
    chk("out_valid16", 32'(b16.out_valid), 32'(occ != 0));
    if (b16.out_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got %h, expected no word", b16.out_data);
      end else begin
        chk("out_data16", 32'(b16.out_data), 32'(q[0]));
        chk("out_data32", b32.out_data, {~q[0], q[0]});
        if (out_ready) void'(q.pop_front());
      end
    end else begin
      chk("bubble16", 32'(b16.out_data), 32'h0);
      chk("bubble32", b32.out_data, 32'h00000013);
    end
  end

  // Driver: one clock of stimulus; pushes the expected word when the model says it is accepted.
  task automatic cyc(input logic v, input logic [15:0] d, input logic r, input logic f);
    logic acc;
    logic con;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    acc = v && (occ != 2);
    con = r && (occ != 0);
    if (f) begin
      q.delete();
      occ = 0;
    end else begin
      if (acc) q.push_back(d);
      occ = occ + int'(acc) - int'(con);
    end
    #1;
  endtask

  task automatic dchk(input string name, input int exp_cnt, input logic [15:0] exp_data);
    chk({name, "_cnt"}, 32'(b16.count), 32'(exp_cnt));
    chk({name, "_rdy"}, 32'(b16.in_ready), 32'(exp_cnt != 2));
    chk({name, "_data"}, 32'(b16.out_data), 32'(exp_data));
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    dchk("reset_noclk", 0, 16'h0000);
    chk("reset_valid", 32'(b16.out_valid), 32'h0);
    chk("reset_bubble32", b32.out_data, 32'h00000013);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    dchk("idle", 0, 16'h0000);
    chk("idle_bubble32", b32.out_data, 32'h00000013);

    cyc(1'b1, 16'h1111, 1'b1, 1'b0); dchk("stream1", 1, 16'h1111);
    chk("stream1_32", b32.out_data, 32'hEEEE1111);
    cyc(1'b1, 16'h2222, 1'b1, 1'b0); dchk("stream2", 1, 16'h2222);
    cyc(1'b1, 16'h3333, 1'b1, 1'b0); dchk("stream3", 1, 16'h3333);
    cyc(1'b0, 16'hDEAD, 1'b1, 1'b0); dchk("stream_drain", 0, 16'h0000);

    cyc(1'b1, 16'hAAAA, 1'b1, 1'b0); dchk("stall_load", 1, 16'hAAAA);
    cyc(1'b1, 16'hBBBB, 1'b0, 1'b0); dchk("stall_skid", 2, 16'hAAAA);
    cyc(1'b1, 16'hCCCC, 1'b0, 1'b0); dchk("stall_hold", 2, 16'hAAAA);
    cyc(1'b1, 16'hCCCC, 1'b1, 1'b0); dchk("stall_rel1", 1, 16'hBBBB);
    cyc(1'b1, 16'hCCCC, 1'b1, 1'b0); dchk("stall_rel2", 1, 16'hCCCC);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0); dchk("stall_drain", 0, 16'h0000);

    cyc(1'b1, 16'h1234, 1'b0, 1'b0); dchk("flush_fill1", 1, 16'h1234);
    cyc(1'b1, 16'h5678, 1'b0, 1'b0); dchk("flush_fill2", 2, 16'h1234);
    cyc(1'b1, 16'h9999, 1'b0, 1'b1); dchk("flush_full", 0, 16'h0000);
    chk("flush_full_valid", 32'(b16.out_valid), 32'h0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0); dchk("flush_after", 0, 16'h0000);
    cyc(1'b1, 16'h4444, 1'b0, 1'b0); dchk("flush_one_fill", 1, 16'h4444);
    cyc(1'b1, 16'h5555, 1'b1, 1'b1); dchk("flush_one", 0, 16'h0000);

    cyc(1'b1, 16'h0001, 1'b1, 1'b0); dchk("simul1", 1, 16'h0001);
    cyc(1'b1, 16'h0002, 1'b1, 1'b0); dchk("simul2", 1, 16'h0002);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    cyc(1'b1, 16'h7777, 1'b0, 1'b0);
    cyc(1'b1, 16'h8888, 1'b0, 1'b0); dchk("pre_reset", 2, 16'h7777);
    in_valid  = 1'b1;
    in_data   = 16'h6666;
    out_ready = 1'b1;
    #2 rst = 1'b0;
    q.delete();
    occ = 0;
    #1;
    dchk("reset_async", 0, 16'h0000);
    chk("reset_async_valid", 32'(b16.out_valid), 32'h0);
    chk("reset_async32", b32.out_data, 32'h00000013);
    @(posedge clk);
    #1 rst = 1'b1;
    dchk("reset_no_xfer", 0, 16'h0000);
    cyc(1'b1, 16'h9A9A, 1'b1, 1'b0); dchk("reset_first", 1, 16'h9A9A);

    for (int i = 0; i < 10000; i++) begin
      cyc(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 49) == 0));
    end
    repeat (4) cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("drained", 32'(q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
